// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes and
// datapath select codes.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_AUIPC,
        S_TRAP, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_LUI, OP_AUIPC: return IMM_U;
            OP_JAL:           return IMM_J;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the controller (master) and the datapath (slave).
interface multicycle_control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       BusError;
    logic       IllegalInstr;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, BusError, IllegalInstr
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, BusError, IllegalInstr
    );
endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU operation decode: fixed add/sub for address and branch work, funct3-driven
// selection for R/I arithmetic (op5 separates R-type sub from addi).
module multicycle_control_fsm_alu_decoder
    import multicycle_control_fsm_pkg::*;
(
    input  aluop_t     alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    3'b111:  alu_ctrl_o = ALU_AND;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main controller with memory wait states and bus watchdog.
// Optional `ILLEGAL_TRAP_EN: unsupported opcodes trap to HALT with a sticky IllegalInstr.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)
(
    input  logic                           clk,
    input  logic                           rst_n,
    multicycle_control_fsm_if.master       bus
);

    localparam bit WD_EN = (MEM_TIMEOUT != 0);
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             bus_err_q;
    logic             mem_wait, timeout, strobe_en;
    logic             pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0]       result_src, alu_src_a, alu_src_b;
    aluop_t           alu_op;

    assign mem_wait = (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !bus.MemReady;
    assign timeout  = WD_EN && mem_wait && (wd_q == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
            S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
            S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
            S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL: state_d = S_ALUWB;
            S_TRAP, S_HALT: state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_HALT;
    end

    // Watchdog only runs while stalled in the same memory state.
    assign wd_d = (WD_EN && mem_wait && (state_d == state_q)) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wd_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  illegal_q <= 1'b0;
        else if (state_q == S_TRAP)  illegal_q <= 1'b1;
    end
    assign bus.IllegalInstr = illegal_q;
`else
    assign bus.IllegalInstr = 1'b0;
`endif

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
            end
            S_DECODE: begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
            S_MEMADR: begin alu_src_a = SRCA_RD1;   alu_src_b = SRCB_IMM; end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; end
            S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
            S_EXECR:    begin alu_src_a = SRCA_RD1; alu_op = ALUOP_FUNCT; end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_LUI:      begin alu_src_a = SRCA_ZERO;  alu_src_b = SRCB_IMM; end
            S_AUIPC:    begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                pc_write  = bus.Zero ^ bus.funct3[0];
            end
            default: ;
        endcase
    end

    // Strobes are suppressed while in reset and on the watchdog's terminal cycle.
    assign strobe_en      = rst_n & ~timeout;
    assign bus.PCWrite    = pc_write  & strobe_en;
    assign bus.IRWrite    = ir_write  & strobe_en;
    assign bus.MemWrite   = mem_write & strobe_en;
    assign bus.RegWrite   = reg_write & strobe_en;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src(bus.op);
    assign bus.BusError   = bus_err_q;

    multicycle_control_fsm_alu_decoder u_alu_dec (
        .alu_op_i   (alu_op),
        .funct3_i   (bus.funct3),
        .funct7b5_i (bus.funct7b5),
        .op5_i      (bus.op[5]),
        .alu_ctrl_o (bus.ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-cycle stimulus items carry the
// expected state; expected outputs are queued on drive and compared one cycle-phase later.
module tb_multicycle_control_fsm;

    typedef enum int {
        B_FETCH, B_DECODE, B_MEMADR, B_MEMREAD, B_MEMWB, B_MEMWRITE, B_EXECR,
        B_EXECI, B_ALUWB, B_JAL, B_BRANCH, B_LUI, B_AUIPC, B_TRAP, B_HALT
    } bst_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       mr;
        logic       z;
        bst_t       st;
        logic       be;
        logic       il;
        logic       to;
    } item_t;

    logic clk;
    logic rst_n;
    multicycle_control_fsm_if bus();

    multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [18:0] dut_vec;
    logic [5:0]  strobe_vec;
    assign dut_vec = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                      bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                      bus.ImmSrc, bus.BusError, bus.IllegalInstr};
    assign strobe_vec = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite,
                         bus.BusError, bus.IllegalInstr};

    item_t       stim_q[$];
    logic [18:0] exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          seq_no = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic       cur_be;
    logic       cur_il;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [2:0] exp_alu(input item_t it);
        case (it.f3)
            3'b000:  return (it.op == 7'b0110011 && it.f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] model(input item_t it);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] res, sa, sb;
        logic [2:0] alu, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
        case (it.op)
            7'b0100011:             imm = 3'b001;
            7'b1100011:             imm = 3'b010;
            7'b0110111, 7'b0010111: imm = 3'b011;
            7'b1101111:             imm = 3'b100;
            default:                imm = 3'b000;
        endcase
        case (it.st)
            B_FETCH:    begin sb = 2'b10; res = 2'b10; irw = it.mr; pcw = it.mr; end
            B_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            B_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            B_MEMREAD:  adr = 1;
            B_MEMWB:    begin res = 2'b01; rw = 1; end
            B_MEMWRITE: begin adr = 1; mw = 1; end
            B_EXECR:    begin sa = 2'b10; alu = exp_alu(it); end
            B_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = exp_alu(it); end
            B_LUI:      begin sa = 2'b11; sb = 2'b01; end
            B_AUIPC:    begin sa = 2'b01; sb = 2'b01; end
            B_ALUWB:    rw = 1;
            B_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            B_BRANCH:   begin sa = 2'b10; alu = 3'b001; pcw = it.z ^ it.f3[0]; end
            default: ;
        endcase
        if (it.to) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
        return {pcw, adr, mw, irw, rw, res, sa, sb, alu, imm, it.be, it.il};
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cur_op = op; cur_f3 = f3; cur_f7 = f7;
    endtask

    task automatic put(input bst_t st, input logic mr = 1'b1, input logic z = 1'b0,
                       input logic to = 1'b0);
        item_t it;
        it.op = cur_op; it.f3 = cur_f3; it.f7 = cur_f7;
        it.mr = mr; it.z = z; it.st = st; it.be = cur_be; it.il = cur_il; it.to = to;
        stim_q.push_back(it);
    endtask

    // Entered and left at a falling edge.
    task automatic run();
        item_t it;
        logic [18:0] e;
        while (stim_q.size() > 0) begin
            it = stim_q.pop_front();
            bus.op = it.op; bus.funct3 = it.f3; bus.funct7b5 = it.f7;
            bus.MemReady = it.mr; bus.Zero = it.z;
            exp_q.push_back(model(it));
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_%0d", it.st.name(), seq_no), {13'b0, dut_vec}, {13'b0, e});
            seq_no++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        bus.MemReady = 1'b1;
        #1 check("rst_async", {26'b0, strobe_vec}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check("rst_hold", {26'b0, strobe_vec}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_be = 1'b0;
        cur_il = 1'b0;
    endtask

    logic [6:0] alu_ops [8] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011,
                                7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
    logic [2:0] alu_f3  [8] = '{3'b000, 3'b000, 3'b000, 3'b110, 3'b111, 3'b010,
                                3'b001, 3'b110};
    logic       alu_f7  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.MemReady = 1'b0;
        cur_be = 1'b0; cur_il = 1'b0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        do_reset();

        // lw, no waits, then with fetch and read wait states
        put(B_FETCH); put(B_DECODE); put(B_MEMADR, 1'b0); put(B_MEMREAD); put(B_MEMWB);
        put(B_FETCH, 1'b0); put(B_FETCH); put(B_DECODE); put(B_MEMADR);
        put(B_MEMREAD, 1'b0); put(B_MEMREAD, 1'b0); put(B_MEMREAD, 1'b0);
        put(B_MEMREAD, 1'b1); put(B_MEMWB);
        // sw with three wait cycles
        set_instr(7'b0100011, 3'b010, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_MEMADR);
        put(B_MEMWRITE, 1'b0); put(B_MEMWRITE, 1'b0); put(B_MEMWRITE, 1'b0);
        put(B_MEMWRITE, 1'b1);
        // bne taken / not taken, beq taken
        set_instr(7'b1100011, 3'b001, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_BRANCH, 1'b1, 1'b0);
        put(B_FETCH); put(B_DECODE, 1'b1, 1'b1); put(B_BRANCH, 1'b1, 1'b1);
        set_instr(7'b1100011, 3'b000, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_BRANCH, 1'b0, 1'b1);
        // R/I arithmetic decode
        for (int i = 0; i < 8; i++) begin
            set_instr(alu_ops[i], alu_f3[i], alu_f7[i]);
            put(B_FETCH); put(B_DECODE);
            put(alu_ops[i][5] ? B_EXECR : B_EXECI); put(B_ALUWB);
        end
        set_instr(7'b1101111, 3'b000, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_JAL); put(B_ALUWB);
        set_instr(7'b0110111, 3'b000, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_LUI); put(B_ALUWB);
        set_instr(7'b0010111, 3'b000, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_AUIPC); put(B_ALUWB);
        // lw aborted by reset mid-instruction
        set_instr(7'b0000011, 3'b010, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_MEMADR);
        run();
        do_reset();
        put(B_FETCH); put(B_DECODE); put(B_MEMADR); put(B_MEMREAD); put(B_MEMWB);
        // unsupported opcode
        set_instr(7'b1111111, 3'b000, 1'b0);
        put(B_FETCH); put(B_DECODE);
`ifdef ILLEGAL_TRAP_EN
        put(B_TRAP);
        cur_il = 1'b1;
        put(B_HALT); put(B_HALT);
        run();
        do_reset();
`endif
        // fetch watchdog expiry
        set_instr(7'b0010011, 3'b000, 1'b0);
        put(B_FETCH, 1'b0); put(B_FETCH, 1'b0); put(B_FETCH, 1'b0);
        put(B_FETCH, 1'b0, 1'b0, 1'b1);
        cur_be = 1'b1;
        put(B_HALT); put(B_HALT); put(B_HALT);
        run();
        do_reset();
        // store watchdog expiry suppresses MemWrite on the terminal cycle
        set_instr(7'b0100011, 3'b010, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_MEMADR);
        put(B_MEMWRITE, 1'b0); put(B_MEMWRITE, 1'b0); put(B_MEMWRITE, 1'b0);
        put(B_MEMWRITE, 1'b0, 1'b0, 1'b1);
        cur_be = 1'b1;
        put(B_HALT); put(B_HALT);
        run();
        do_reset();
        set_instr(7'b0010011, 3'b111, 1'b0);
        put(B_FETCH); put(B_DECODE); put(B_EXECI); put(B_ALUWB); put(B_FETCH);
        run();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
